// File: rtl/ddr_tx_pkg.sv
// Shared types and helpers for the DDR transmit serializer.
// Words up to 64 bits wide are supported by the pair-select helper.
package ddr_tx_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, TAIL} state_t;

   localparam int MAX_W = 64;

   function automatic int pair_cnt_w(input int data_w);
      return (data_w / 2 > 1) ? $clog2(data_w / 2) : 1;
   endfunction

   // Returns {d1, d2} for pair k of a word; MSB-first mode mirrors bit order.
   function automatic logic [1:0] get_pair(input logic [MAX_W-1:0] word,
                                           input int k,
                                           input int data_w,
                                           input bit lsb_first);
      logic [5:0] first_idx;
      logic [5:0] second_idx;
      if (lsb_first) begin
         first_idx  = 6'(2 * k);
         second_idx = 6'(2 * k + 1);
      end else begin
         first_idx  = 6'(data_w - 1 - 2 * k);
         second_idx = 6'(data_w - 2 - 2 * k);
      end
      return {word[first_idx], word[second_idx]};
   endfunction

endpackage

// File: rtl/ddr_tx_if.sv
// Valid/ready word handshake plus the enable gate feeding the serializer.
interface ddr_tx_if #(parameter int DATA_W = 16) ();
   import ddr_tx_pkg::*;

   logic              enable;
   logic [DATA_W-1:0] s_data;
   logic              s_valid;
   logic              s_ready;

   modport master (output enable, s_data, s_valid, input s_ready);
   modport slave  (input enable, s_data, s_valid, output s_ready);
endinterface

// File: rtl/ddr_tx_serializer.sv
// Feeds an ODDR/IOBUF pair: serializes words two bits per clock on d1/d2,
// with a one-word holding register for gapless streaming and an OE tail.
module ddr_tx_serializer
   import ddr_tx_pkg::*;
#(
   parameter int   DATA_W     = 16,
   parameter bit   LSB_FIRST  = 1'b1,
   parameter logic IDLE_LEVEL = 1'b0,
   parameter int   OE_TAIL    = 2
) (
   input  logic     clk,
   input  logic     rst_n,
   ddr_tx_if.slave  s,
   output logic     d1,
   output logic     d2,
   output logic     oe,
   output logic     busy
);

   localparam int             PAIRS     = DATA_W / 2;
   localparam int             CW        = pair_cnt_w(DATA_W);
   localparam logic [CW-1:0]  LAST_PAIR = CW'(PAIRS - 1);
   localparam int             TW        = (OE_TAIL > 1) ? $clog2(OE_TAIL) : 1;
   localparam logic [TW-1:0]  LAST_TAIL = TW'((OE_TAIL > 0) ? OE_TAIL - 1 : 0);

   state_t            state;
   logic [DATA_W-1:0] cur_word;
   logic [DATA_W-1:0] hold_word;
   logic              hold_valid;
   logic              hold_valid_nxt;
   logic [CW-1:0]     pair_cnt;
   logic [TW-1:0]     tail_cnt;
   logic              xfer;
   logic              last_pair;
   logic [1:0]        next_pair;
   logic [1:0]        in_pair0;
   logic [1:0]        hold_pair0;

   // s_ready looks one cycle ahead so the holding register is never overwritten.
   always_comb begin
      xfer           = s.s_valid && s.s_ready;
      last_pair      = (state == SHIFT) && (pair_cnt == LAST_PAIR);
      hold_valid_nxt = hold_valid;
      if (state == SHIFT) begin
         if (last_pair)
            hold_valid_nxt = 1'b0;
         else if (xfer)
            hold_valid_nxt = 1'b1;
      end
      next_pair  = get_pair(MAX_W'(cur_word), int'(pair_cnt) + 1, DATA_W, LSB_FIRST);
      in_pair0   = get_pair(MAX_W'(s.s_data), 0, DATA_W, LSB_FIRST);
      hold_pair0 = get_pair(MAX_W'(hold_word), 0, DATA_W, LSB_FIRST);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         cur_word   <= '0;
         hold_word  <= '0;
         hold_valid <= 1'b0;
         pair_cnt   <= '0;
         tail_cnt   <= '0;
         d1         <= IDLE_LEVEL;
         d2         <= IDLE_LEVEL;
         oe         <= 1'b0;
         busy       <= 1'b0;
         s.s_ready  <= 1'b0;
      end else begin
         s.s_ready  <= s.enable && !hold_valid_nxt;
         hold_valid <= hold_valid_nxt;
         case (state)
            IDLE: begin
               if (xfer) begin
                  cur_word <= s.s_data;
                  {d1, d2} <= in_pair0;
                  pair_cnt <= '0;
                  oe       <= 1'b1;
                  busy     <= 1'b1;
                  state    <= SHIFT;
               end
            end
            SHIFT: begin
               if (!last_pair) begin
                  pair_cnt <= pair_cnt + 1'b1;
                  {d1, d2} <= next_pair;
                  if (xfer)
                     hold_word <= s.s_data;
               end else if (hold_valid) begin
                  cur_word <= hold_word;
                  {d1, d2} <= hold_pair0;
                  pair_cnt <= '0;
               end else if (xfer) begin
                  cur_word <= s.s_data;
                  {d1, d2} <= in_pair0;
                  pair_cnt <= '0;
               end else begin
                  {d1, d2} <= {2{IDLE_LEVEL}};
                  pair_cnt <= '0;
                  tail_cnt <= '0;
                  if (OE_TAIL == 0) begin
                     oe    <= 1'b0;
                     busy  <= 1'b0;
                     state <= IDLE;
                  end else begin
                     state <= TAIL;
                  end
               end
            end
            TAIL: begin
               if (xfer) begin
                  cur_word <= s.s_data;
                  {d1, d2} <= in_pair0;
                  pair_cnt <= '0;
                  tail_cnt <= '0;
                  state    <= SHIFT;
               end else if (tail_cnt == LAST_TAIL) begin
                  tail_cnt <= '0;
                  oe       <= 1'b0;
                  busy     <= 1'b0;
                  state    <= IDLE;
               end else begin
                  tail_cnt <= tail_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ddr_tx_serializer.sv
// Bench for ddr_tx_serializer: LSB-first and MSB-first instances share stimulus,
// and a per-cycle scoreboard of expected pairs and OE tail checks both.
module tb_ddr_tx_serializer;

   localparam int   DATA_W     = 8;
   localparam int   HALF       = DATA_W / 2;
   localparam int   OE_TAIL    = 2;
   localparam logic IDLE_LEVEL = 1'b0;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   ddr_tx_if #(.DATA_W(DATA_W)) bus_lsb ();
   ddr_tx_if #(.DATA_W(DATA_W)) bus_msb ();

   assign bus_msb.enable  = bus_lsb.enable;
   assign bus_msb.s_data  = bus_lsb.s_data;
   assign bus_msb.s_valid = bus_lsb.s_valid;

   logic d1_l, d2_l, oe_l, busy_l;
   logic d1_m, d2_m, oe_m, busy_m;

   ddr_tx_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b1), .IDLE_LEVEL(IDLE_LEVEL), .OE_TAIL(OE_TAIL))
      dut_lsb (.clk(clk), .rst_n(rst_n), .s(bus_lsb), .d1(d1_l), .d2(d2_l), .oe(oe_l), .busy(busy_l));

   ddr_tx_serializer #(.DATA_W(DATA_W), .LSB_FIRST(1'b0), .IDLE_LEVEL(IDLE_LEVEL), .OE_TAIL(OE_TAIL))
      dut_msb (.clk(clk), .rst_n(rst_n), .s(bus_msb), .d1(d1_m), .d2(d2_m), .oe(oe_m), .busy(busy_m));

   int         total = 0;
   int         bad   = 0;
   logic [3:0] exp_q[$];
   int         tail_left = 0;
   logic       en_prev = 1'b0;

   function automatic logic [1:0] lsb_pair(input logic [7:0] w, input int k);
      return {w[3'(2 * k)], w[3'(2 * k + 1)]};
   endfunction

   function automatic logic [1:0] msb_pair(input logic [7:0] w, input int k);
      return {w[3'(7 - 2 * k)], w[3'(6 - 2 * k)]};
   endfunction

   // Every accepted word queues its four pairs for both bit orders.
   always @(posedge clk) begin
      if (rst_n && bus_lsb.s_valid && bus_lsb.s_ready) begin
         for (int k = 0; k < HALF; k++)
            exp_q.push_back({lsb_pair(bus_lsb.s_data, k), msb_pair(bus_lsb.s_data, k)});
      end
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) en_prev = 1'b0;
      else        en_prev = bus_lsb.enable;
   end

   // Per-cycle stream model: queued pairs first, then OE_TAIL idle cycles with oe high.
   always @(negedge clk) begin
      logic       exp_rdy;
      logic [3:0] e;
      logic [7:0] got, want;
      if (!rst_n) begin
         exp_q.delete();
         tail_left = 0;
      end else begin
         exp_rdy = en_prev && (exp_q.size() <= HALF);
         total++;
         if (bus_lsb.s_ready !== exp_rdy || bus_msb.s_ready !== exp_rdy) begin
            bad++;
            $display("[TB] FAIL s_ready t=%0t got=%b/%b want=%b", $time, bus_lsb.s_ready, bus_msb.s_ready, exp_rdy);
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            want = {e, 4'b1111};
            tail_left = OE_TAIL;
         end else if (tail_left > 0) begin
            want = {{4{IDLE_LEVEL}}, 4'b1111};
            tail_left--;
         end else begin
            want = {{4{IDLE_LEVEL}}, 4'b0000};
         end
         got = {d1_l, d2_l, d1_m, d2_m, oe_l, busy_l, oe_m, busy_m};
         total++;
         if (got !== want) begin
            bad++;
            $display("[TB] FAIL stream t=%0t got=%b want=%b", $time, got, want);
         end
      end
   end

   task automatic send_word(input logic [7:0] w);
      bus_lsb.s_valid = 1'b1;
      bus_lsb.s_data  = w;
      for (int i = 0; i < 50 && bus_lsb.s_ready !== 1'b1; i++) @(negedge clk);
      total++;
      if (bus_lsb.s_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL handshake_timeout word=%h got_ready=%b want=1", w, bus_lsb.s_ready);
      end
      @(negedge clk);
   endtask

   task automatic drop_valid();
      bus_lsb.s_valid = 1'b0;
      bus_lsb.s_data  = 8'($urandom);
   endtask

   task automatic check_idle(input string name);
      total++;
      if ({oe_l, busy_l, oe_m, busy_m, d1_l, d2_l} !== {4'b0000, {2{IDLE_LEVEL}}}) begin
         bad++;
         $display("[TB] FAIL %s got oe/busy/d=%b%b%b%b%b%b want=000000", name,
                  oe_l, busy_l, oe_m, busy_m, d1_l, d2_l);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus_lsb.enable  = 1'b1;
      bus_lsb.s_valid = 1'b0;
      bus_lsb.s_data  = 8'h00;
      #1;
      total++;
      if ({d1_l, d2_l, oe_l, busy_l, bus_lsb.s_ready, d1_m, d2_m, oe_m} !== 8'b0) begin
         bad++;
         $display("[TB] FAIL reset_values got=%b want=00000000",
                  {d1_l, d2_l, oe_l, busy_l, bus_lsb.s_ready, d1_m, d2_m, oe_m});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      total++;
      if (bus_lsb.s_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ready_after_release got=%b want=0", bus_lsb.s_ready);
      end
      @(negedge clk);
      total++;
      if (bus_lsb.s_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_first_rise got=%b want=1", bus_lsb.s_ready);
      end
   endtask

   task automatic test_single();
      send_word(8'hB4);
      drop_valid();
      repeat (8) @(negedge clk);
      check_idle("single_idle");
   endtask

   task automatic test_back_to_back();
      send_word(8'hB4);
      send_word(8'h0F);
      drop_valid();
      repeat (12) @(negedge clk);
      check_idle("b2b_idle");
   endtask

   task automatic test_enable_stop();
      send_word(8'h3C);
      bus_lsb.enable = 1'b0;
      send_word(8'hA5);
      bus_lsb.s_valid = 1'b1;
      bus_lsb.s_data  = 8'hFF;
      repeat (14) @(negedge clk);
      total++;
      if (bus_lsb.s_ready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL ready_while_disabled got=%b want=0", bus_lsb.s_ready);
      end
      check_idle("enable_stop_idle");
      drop_valid();
      bus_lsb.enable = 1'b1;
      @(negedge clk);
      total++;
      if (bus_lsb.s_ready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL ready_reenable got=%b want=1", bus_lsb.s_ready);
      end
   endtask

   task automatic test_reset_midword();
      send_word(8'hB4);
      drop_valid();
      @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      total++;
      if ({d1_l, d2_l, oe_l, busy_l, bus_lsb.s_ready, d1_m, d2_m, oe_m} !== 8'b0) begin
         bad++;
         $display("[TB] FAIL midword_reset got=%b want=00000000",
                  {d1_l, d2_l, oe_l, busy_l, bus_lsb.s_ready, d1_m, d2_m, oe_m});
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      send_word(8'h5A);
      drop_valid();
      repeat (8) @(negedge clk);
      check_idle("post_reset_idle");
   endtask

   task automatic test_tail_restart();
      send_word(8'hC3);
      drop_valid();
      repeat (4) @(negedge clk);
      total++;
      if ({oe_l, busy_l, d1_l, d2_l} !== {2'b11, {2{IDLE_LEVEL}}}) begin
         bad++;
         $display("[TB] FAIL tail_cycle1 got=%b want=11%b%b", {oe_l, busy_l, d1_l, d2_l}, IDLE_LEVEL, IDLE_LEVEL);
      end
      send_word(8'h96);
      drop_valid();
      repeat (8) @(negedge clk);
      check_idle("tail_restart_idle");
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_enable_stop();
      test_reset_midword();
      test_tail_restart();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout want=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/ddr_tx_serializer.md
Name: ddr_tx_serializer

Overview:
- Upstream feeder for the ODDRE1/IOBUF output stage.
- Accepts parallel words over a valid/ready handshake and emits them 2 bits per clk as D1/D2 pairs.
- Drives an output-enable that the IOBUF stage inverts onto T.
- Supports back-to-back words with no gap via a one-word holding register, plus a configurable OE tail before release.

Parameters:
- DATA_W, 16, word width; must be even and >= 4.
- LSB_FIRST, 1, 1: pair k = {bit 2k -> d1, bit 2k+1 -> d2}; 0: MSB-first mirror (bit DATA_W-1-2k -> d1, bit DATA_W-2-2k -> d2).
- IDLE_LEVEL, 1'b0, value driven on d1/d2 when not shifting.
- OE_TAIL, 2, cycles oe stays high after the last pair (0 allowed).

Ports:
- clk, input, 1, single clock; same clock as the ODDR stage.
- rst_n, input, 1, asynchronous active-low reset.
- enable, input, 1, permission to accept new words.
- s_data, input, DATA_W, word to transmit.
- s_valid, input, 1, s_data valid.
- s_ready, output, 1, registered; transfer occurs when s_valid && s_ready at a clk edge.
- d1, output, 1, registered; ODDR D1 (first half-period).
- d2, output, 1, registered; ODDR D2 (second half-period).
- oe, output, 1, registered; 1 = drive pad (downstream uses T = ~oe).
- busy, output, 1, registered; high in SHIFT or TAIL.

Behaviour:
- Reset (async assert, sync release): d1 = d2 = IDLE_LEVEL, oe = 0, busy = 0, s_ready = 0, holding register empty, state IDLE, counters 0.
- s_ready next = enable && holding register will be empty next cycle. It first rises in the cycle after reset release if enable = 1.
- States:
  - IDLE: transfer loads the word into the shift register, d1/d2 <= pair 0, oe <= 1, goes to SHIFT.
  - SHIFT: pair counter 0..DATA_W/2-1. Each cycle d1/d2 <= next pair.
    - On the last pair, if the holding register is valid, its pair 0 follows on the very next cycle (seamless) and the holding register empties.
    - If the holding register is empty but a transfer happens in that same cycle, the accepted word goes straight to the shift register (seamless).
    - Otherwise go to TAIL (or IDLE if OE_TAIL = 0).
  - TAIL: d1 = d2 = IDLE_LEVEL, oe = 1, tail counter runs OE_TAIL cycles, then IDLE with oe <= 0.
    - A transfer during TAIL goes to SHIFT next cycle with pair 0; the tail counter is cleared.
- A transfer during SHIFT, when the holding register is empty and it is not the last pair, fills the holding register.
- Latency: transfer at edge N -> pair 0 on d1/d2 during cycle N+1; pair k during cycle N+1+k.
- Throughput: one word per DATA_W/2 cycles sustained.
- enable deassert mid-word is a graceful stop:
  - s_ready drops next cycle.
  - The word in flight and any held word drain completely, then TAIL, then IDLE.
  - enable has no effect on an in-progress transmission.
- Async reset mid-word: immediate return to reset values; partial word and held word discarded; oe low without tail.
- s_data must be ignored when no transfer occurs. The holding register is never overwritten while valid; s_ready guarantees this.

Decomposition:
- Package ddr_tx_pkg:
  - state enum {IDLE, SHIFT, TAIL}.
  - Function get_pair(word, k, lsb_first) returning {d1, d2}.
  - Localparam helper for pair-counter width, $clog2(DATA_W/2).
- No sub-module required. Datapath (holding register + shift register) and control FSM stay in one module.

Test Plan:
- DATA_W=8, LSB_FIRST=1, IDLE_LEVEL=0, OE_TAIL=2; send 0xB4 once -> d1 = 0,1,1,0 and d2 = 0,0,1,1 in cycles N+1..N+4; oe high N+1..N+6; oe = 0 and busy = 0 from N+7.
- Same config; s_valid held with 0xB4 then 0x0F back-to-back -> 8 consecutive pair cycles with no idle gap; second word gives d1 = 1,1,0,0 and d2 = 1,1,0,0; s_ready low while the holding register is full.
- LSB_FIRST=0, send 0xB4 -> d1 = 1,1,0,0 and d2 = 0,1,1,0.
- Deassert enable one cycle after accepting the first of two queued words -> both words fully transmitted, then 2 tail cycles; s_ready stays 0 until enable returns.
- Assert rst_n = 0 during pair 2 -> same cycle: d1 = d2 = 0, oe = 0, s_ready = 0; after release, a fresh word transmits correctly from pair 0.
- New word accepted during tail cycle 1 -> pair 0 in the next cycle, oe never drops, tail restarts only after that word.
